// File: rtl/pio_read_arbiter.sv
// -----------------------------------------------------------------------------
// pio_read_arbiter
//
// Round-robin read arbiter sharing one Avalon-MM PIO input slave (registered
// readdata, one cycle of latency) among N_REQ on-chip requesters. One read is
// in flight at a time: grant (drive s_address), wait one cycle for the slave
// to register readdata, then capture it and pulse ack for the winner.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   req         per-requester request level (bit i = requester i)
//   req_addr    packed requester addresses, slice [i*ADDR_W +: ADDR_W]
//   ack         one-hot, one-cycle pulse: rsp_data valid for that requester
//   rsp_data    captured slave data, held until the next capture
//   busy        high while a transaction is in flight (GRANT, CAPTURE)
//   s_address   registered address to the slave
//   s_readdata  slave readdata, valid one cycle after s_address changes
// -----------------------------------------------------------------------------
module pio_read_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy,
  output logic [ADDR_W-1:0]       s_address,
  input  logic [DATA_W-1:0]       s_readdata
);

  // A single requester still needs a 1-bit index so the pointer logic is legal.
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_CAPTURE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   s_address_q, s_address_d;

  logic [IDX_W-1:0]        pick;
  logic [N_REQ*ADDR_W-1:0] addr_sh;

  // Round-robin search: scan from ptr_q upward, wrapping modulo N_REQ; the
  // first set request wins. Shifts are used instead of variable bit-selects
  // so the index width never has to match the vector width.
  always_comb begin : rr_search
    logic [N_REQ-1:0] req_sh;
    logic             found;
    int               idx;
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves a variable unassigned would infer a latch.
    pick   = '0;
    found  = 1'b0;
    req_sh = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx    = (int'(ptr_q) + k) % N_REQ;
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // Address of the selected requester, aligned to bit 0.
  assign addr_sh = req_addr >> (int'(pick) * ADDR_W);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req) state_d = ST_GRANT;
      ST_GRANT:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic. req_addr is only looked at on the grant edge,
  // so later changes cannot disturb the transaction in flight.
  always_comb begin
    winner_d    = winner_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    s_address_d = s_address_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          winner_d    = pick;
          s_address_d = addr_sh[ADDR_W-1:0];
          busy_d      = 1'b1;
        end
      end
      ST_CAPTURE: begin
        rsp_data_d = s_readdata;
        ack_d      = N_REQ'(1) << winner_q;
        busy_d     = 1'b0;
        // Winner drops to lowest priority; with one requester this stays 0.
        ptr_d      = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // State register. Reset aborts any transaction without issuing ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      winner_q    <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      s_address_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      winner_q    <= winner_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      s_address_q <= s_address_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign s_address = s_address_q;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pio_read_arbiter
//
// Directed bench for pio_read_arbiter (N_REQ=4, DATA_W=8, ADDR_W=2). A small
// registered-readdata slave model returns a fixed pattern per address.
// Requester i uses address i unless a sequence says otherwise.
// -----------------------------------------------------------------------------
module tb_pio_read_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;

  logic                    clk;
  logic                    reset;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        ack;
  logic [DATA_W-1:0]       rsp_data;
  logic                    busy;
  logic [ADDR_W-1:0]       s_address;
  logic [DATA_W-1:0]       s_readdata;

  logic [DATA_W-1:0] slave_mem [0:3];

  int n_tests;
  int n_fail;

  pio_read_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .ack        (ack),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .s_address  (s_address),
    .s_readdata (s_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave with one cycle of registered read latency.
  always @(posedge clk) s_readdata <= slave_mem[s_address];

  typedef struct {
    logic              rst;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  ack;
    logic              busy;
    logic [DATA_W-1:0] rsp;
    logic [ADDR_W-1:0] sa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] a,
                     input logic b, input logic [7:0] d, input logic [1:0] s);
    vec_t v;
    v.rst = r; v.req = rq; v.ack = a; v.busy = b; v.rsp = d; v.sa = s;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] a, input logic b,
                           input logic [7:0] d, input logic [1:0] s);
    check({tag, " ack"},       32'(ack),       32'(a));
    check({tag, " busy"},      32'(busy),      32'(b));
    check({tag, " rsp_data"},  32'(rsp_data),  32'(d));
    check({tag, " s_address"}, 32'(s_address), 32'(s));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    slave_mem[0] = 8'h5A;
    slave_mem[1] = 8'hA1;
    slave_mem[2] = 8'hB2;
    slave_mem[3] = 8'hC3;
    reset    = 1'b1;
    req      = '0;
    req_addr = 8'hE4;   // requester i -> address i
    s_readdata = '0;

    // ---- table: reset, single request, round robin, pointer wrap ----
    //   rst  req      exp ack  busy rsp    s_addr
    add(1, 4'b0000, 4'b0000, 0, 8'h00, 0);   // reset state
    add(0, 4'b0001, 4'b0000, 1, 8'h00, 0);   // single: E0 grant 0
    add(0, 4'b0001, 4'b0000, 1, 8'h00, 0);   // E1
    add(0, 4'b0001, 4'b0001, 0, 8'h5A, 0);   // E2: ack in 3rd cycle
    add(0, 4'b0000, 4'b0000, 0, 8'h5A, 0);   // idle, data held
    add(1, 4'b0000, 4'b0000, 0, 8'h00, 0);   // reset before round robin
    add(0, 4'b1111, 4'b0000, 1, 8'h00, 0);   // grant 0
    add(0, 4'b1111, 4'b0000, 1, 8'h00, 0);
    add(0, 4'b1111, 4'b0001, 0, 8'h5A, 0);   // ack 0
    add(0, 4'b1110, 4'b0000, 1, 8'h5A, 1);   // 0 drops; grant 1
    add(0, 4'b1111, 4'b0000, 1, 8'h5A, 1);
    add(0, 4'b1111, 4'b0010, 0, 8'hA1, 1);   // ack 1
    add(0, 4'b1101, 4'b0000, 1, 8'hA1, 2);   // grant 2
    add(0, 4'b1111, 4'b0000, 1, 8'hA1, 2);
    add(0, 4'b1111, 4'b0100, 0, 8'hB2, 2);   // ack 2
    add(0, 4'b1011, 4'b0000, 1, 8'hB2, 3);   // grant 3
    add(0, 4'b1111, 4'b0000, 1, 8'hB2, 3);
    add(0, 4'b1111, 4'b1000, 0, 8'hC3, 3);   // ack 3, pointer wraps to 0
    add(0, 4'b1001, 4'b0000, 1, 8'hC3, 0);   // wrap: 0 first
    add(0, 4'b1001, 4'b0000, 1, 8'hC3, 0);
    add(0, 4'b1001, 4'b0001, 0, 8'h5A, 0);   // ack 0
    add(0, 4'b1000, 4'b0000, 1, 8'h5A, 3);   // then 3
    add(0, 4'b1000, 4'b0000, 1, 8'h5A, 3);
    add(0, 4'b1000, 4'b1000, 0, 8'hC3, 3);   // ack 3
    add(0, 4'b0000, 4'b0000, 0, 8'hC3, 3);   // idle, pointer now 0

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].ack, vecs[i].busy, vecs[i].rsp, vecs[i].sa);
    end
    reset = 1'b0;

    // ---- late arrival: req[2] rises during GRANT of requester 1 ----
    req = 4'b0010; tick();                       // grant 1
    check_out("late grant1", 4'b0000, 1'b1, 8'hC3, 2'd1);
    req = 4'b0110; tick();                       // GRANT -> CAPTURE
    check_out("late wait", 4'b0000, 1'b1, 8'hC3, 2'd1);
    tick();                                      // ack of 1
    check_out("late ack1", 4'b0010, 1'b0, 8'hA1, 2'd1);
    req = 4'b0100; tick();                       // IDLE edge: grant 2
    check_out("late grant2", 4'b0000, 1'b1, 8'hA1, 2'd2);
    tick();
    tick();
    check_out("late ack2", 4'b0100, 1'b0, 8'hB2, 2'd2);
    req = 4'b0000; tick();                       // pointer now 3

    // ---- address change after grant ----
    req = 4'b0001; req_addr = 8'hE4; tick();     // grant 0 at address 0
    check_out("addr grant", 4'b0000, 1'b1, 8'hB2, 2'd0);
    req_addr = 8'hE5; tick();                    // requester 0 now says 1
    check_out("addr hold", 4'b0000, 1'b1, 8'hB2, 2'd0);
    tick();
    check_out("addr ack", 4'b0001, 1'b0, 8'h5A, 2'd0);
    req = 4'b0000; req_addr = 8'hE4; tick();     // pointer now 1

    // ---- reset during CAPTURE ----
    req = 4'b0100; tick();                       // grant 2
    check_out("rst grant", 4'b0000, 1'b1, 8'h5A, 2'd2);
    tick();                                      // now in CAPTURE
    reset = 1'b1; tick();
    check_out("rst abort", 4'b0000, 1'b0, 8'h00, 2'd0);
    reset = 1'b0; req = 4'b0000; tick();
    check_out("rst idle", 4'b0000, 1'b0, 8'h00, 2'd0);
    // Pointer back at 0: 0 must beat 3 (a stale pointer of 1 would pick 3).
    req = 4'b1001; tick();
    check_out("rst ptr", 4'b0000, 1'b1, 8'h00, 2'd0);
    tick();
    tick();
    check_out("rst ack", 4'b0001, 1'b0, 8'h5A, 2'd0);
    req = 4'b0000; tick();
    check_out("final idle", 4'b0000, 1'b0, 8'h5A, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_read_arbiter.md
# pio_read_arbiter

Round-robin read arbiter sharing one Avalon-MM PIO input slave among up to N_REQ on-chip requesters. Typical slaves are the 8-bit number and switch ports, which have a 2-bit address and registered readdata with one cycle of latency. Each requester raises a request with an address. The arbiter grants one requester at a time, drives the slave address, captures the registered readdata and returns it with a one-cycle acknowledge. It sits between the slave's s1 port and the requesting control logic, in place of ad-hoc muxing of the address lines.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, slave readdata width
- ADDR_W, 2, slave address width
- clk  in  1  single system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level; bit i belongs to requester i
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice [i*ADDR_W +: ADDR_W] belongs to requester i
- ack  out  N_REQ  one-hot, one-cycle pulse marking rsp_data valid for that requester
- rsp_data  out  DATA_W  captured slave data; holds until the next capture
- busy  out  1  high while a transaction is in flight (states GRANT and CAPTURE)
- s_address  out  ADDR_W  registered address to the slave
- s_readdata  in  DATA_W  slave readdata; valid one cycle after s_address changes

## Operation
- Reset values: state IDLE, ack=0, rsp_data=0, busy=0, s_address=0, winner=0, priority pointer=0 (requester 0 highest).
- State machine, 3 states:
  - IDLE: if any req bit is high, select the winner, register s_address <= req_addr[winner], set busy, go to GRANT. Otherwise stay in IDLE.
  - GRANT: the slave registers readdata for s_address at the end of this cycle. Go to CAPTURE unconditionally.
  - CAPTURE: rsp_data <= s_readdata, ack[winner] <= 1 for one cycle, pointer <= winner+1 (mod N_REQ), busy <= 0, go to IDLE.
- Arbitration:
  - Search starts at the pointer and wraps modulo N_REQ.
  - The first set req bit wins.
  - Arbitration happens only in IDLE. Requests arriving in GRANT or CAPTURE wait.
- Requester protocol:
  - Hold req and req_addr stable until ack is seen.
  - Deassert req in the cycle ack is high.
  - If req is still high on the edge ending the ack cycle, it counts as a new request.
- req_addr is sampled only at the grant edge. Changes after that edge do not affect the transaction.
- A req dropped after the grant edge is a protocol violation. The transaction still completes and ack is still pulsed.
- Reset asserted in any state aborts the transaction:
  - No ack is issued.
  - All registers return to their reset values on that edge.
- N_REQ=1 degenerates to a plain sequencer: the pointer stays at 0.

## Timing
- Edge E0: req sampled in IDLE, grant made, s_address updated.
- Edge E1: slave readdata updated.
- Edge E2: rsp_data and ack registered.
- ack and rsp_data are visible in the cycle after E2.
- Latency is 3 cycles from request sampled to ack visible.
- The earliest next grant is at E3.
- Sustained throughput is one read per 3 cycles. With all requesters active, each is served once every 3*N_REQ cycles.
- busy is high during the cycles following E0 and E1, and low in the ack cycle.
- At most one ack bit is set in any cycle. ack is never high in two consecutive cycles.
- Combinational paths: none from req/req_addr to the outputs, and none from s_readdata to the outputs. All outputs are registered.

## Test plan
- Single request. Reset, then req=4'b0001 with addr 0 and s_readdata modelled as a registered 0x5A at address 0. Required: ack=4'b0001 in the 3rd cycle after the request edge, rsp_data=0x5A, busy high for exactly 2 cycles.
- Round robin. req=4'b1111 held, each requester dropping and re-raising around its ack. Required: ack order 0,1,2,3,0, spaced 3 cycles apart.
- Pointer wrap. After requester 3 is served, req=4'b1001. Required: requester 0 is granted first, then 3.
- Late arrival. req[2] rises during GRANT of requester 1. Required: requester 2 is not granted until the IDLE edge after the ack of 1. The ack of 1 carries the data for address 1 only.
- Address change after grant. req_addr[0] goes 0 -> 1 the cycle after the grant. Required: s_address stays 0 and rsp_data matches address 0.
- Reset mid-transaction. reset is asserted during CAPTURE. Required: no ack pulse, and the next cycle shows rsp_data=0, busy=0, state IDLE, pointer 0.
